// File: rtl/fp16_add_normalize.sv
// Final FP16 adder stage: renormalizes the aligned magnitude sum, rounds to nearest-even
// and packs an IEEE half word, as a two-stage valid/ready pipeline.
module fp16_add_normalize #(
  parameter int OUT_REG_BYPASS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [13:0] frac_in,
  input  logic [4:0]  exp_in,
  input  logic        sticky_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow
);

  // Bypass is reserved; the output stage is always registered.
  localparam logic OUT_REGISTERED = (OUT_REG_BYPASS == 0);

  logic        s1_valid, s2_valid;
  logic        s1_adv, s2_adv;
  logic [12:0] s1_f;
  logic [5:0]  s1_e;
  logic        s1_s, s1_sign, s1_zero;

  logic [5:0]  e_eff, lz, sh, n_e;
  logic [3:0]  lead;
  logic [12:0] f_sh, n_f;
  logic        n_s;

  logic [10:0] m;
  logic        inc;
  logic [11:0] mr;
  logic [9:0]  mant;
  logic [5:0]  e2;
  logic [15:0] p_result;
  logic        p_ovf;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | (s1_valid & s2_adv);
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid & OUT_REGISTERED;

  // Normalize: left shift is capped so the exponent never drops below 1 (subnormal floor).
  always_comb begin
    e_eff = (exp_in == 5'd0) ? 6'd1 : {1'b0, exp_in};
    lead  = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (frac_in[i]) lead = 4'(i);
    end
    lz   = 6'd12 - {2'b00, lead};
    sh   = (lz < (e_eff - 6'd1)) ? lz : (e_eff - 6'd1);
    f_sh = frac_in[12:0] << sh;
    if (frac_in[13]) begin
      n_f = frac_in[13:1];
      n_s = sticky_in | frac_in[0];
      n_e = e_eff + 6'd1;
    end else begin
      n_f = f_sh;
      n_s = sticky_in;
      n_e = f_sh[12] ? (e_eff - sh) : 6'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
      s1_e     <= '0;
      s1_s     <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_f    <= n_f;
        s1_e    <= n_e;
        s1_s    <= n_s;
        s1_sign <= sign_in;
        s1_zero <= (frac_in == 14'd0);
      end
    end
  end

  // Round-to-nearest-even on the two guard bits plus sticky, then pack.
  always_comb begin
    m   = s1_f[12:2];
    inc = s1_f[1] & (s1_f[0] | s1_s | m[0]);
    mr  = {1'b0, m} + {11'd0, inc};
    e2  = s1_e;
    if (mr[11]) begin
      mant = mr[10:1];
      e2   = s1_e + 6'd1;
    end else begin
      mant = mr[9:0];
      if ((s1_e == 6'd0) && mr[10]) e2 = 6'd1;
    end
    if (s1_zero) begin
      p_result = {s1_sign, 15'd0};
      p_ovf    = 1'b0;
    end else if (e2 >= 6'd31) begin
      p_result = {s1_sign, 5'h1F, 10'h000};
      p_ovf    = 1'b1;
    end else begin
      p_result = {s1_sign, e2[4:0], mant};
      p_ovf    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      result   <= 16'h0000;
      overflow <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result   <= p_result;
        overflow <= p_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp16_add_normalize.sv
// Bench for fp16_add_normalize: directed vectors plus randomized streams scored against
// an exact-value rounding model.
module tb_fp16_add_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        sign_in, sticky_in;
  logic [13:0] frac_in;
  logic [4:0]  exp_in;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  fp16_add_normalize #(.OUT_REG_BYPASS(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .frac_in(frac_in), .exp_in(exp_in), .sticky_in(sticky_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow)
  );

  // Magnitude = frac * 2^(e_eff-27); scaled by 2^27 it is frac<<e_eff, and sticky becomes
  // one unit strictly below every real bit. Rounded directly to the FP16 grid.
  function automatic logic [16:0] model(input logic sgn, input logic [13:0] f,
                                        input logic [4:0] e, input logic st);
    longint unsigned q2, mant, rem, half;
    int h, eb, k, ee;
    if (f == 14'd0) return {1'b0, sgn, 15'd0};
    ee = (e == 5'd0) ? 1 : int'(e);
    q2 = 64'(f);
    q2 = (q2 << ee) | 64'(st);
    h = 0;
    for (int i = 0; i < 64; i++) if (q2[i]) h = i;
    eb = h - 12;
    if (eb < 1) eb = 1;
    k = eb + 2;
    mant = q2 >> k;
    rem  = q2 & ((64'd1 << k) - 64'd1);
    half = 64'd1 << (k - 1);
    if (rem > half || (rem == half && mant[0])) mant = mant + 1;
    if (mant == 64'd2048) begin
      mant = 64'd1024;
      eb = eb + 1;
    end
    if (eb >= 31) return {1'b1, sgn, 5'h1F, 10'h000};
    if (mant < 64'd1024) return {1'b0, sgn, 5'd0, mant[9:0]};
    return {1'b0, sgn, 5'(eb), mant[9:0]};
  endfunction

  // beat = {sign, sticky, exp[4:0], frac[13:0]}
  function automatic logic [16:0] model_beat(input logic [20:0] b);
    return model(b[20], b[13:0], b[18:14], b[19]);
  endfunction

  function automatic logic [20:0] rand_beat();
    logic [13:0] f;
    logic [4:0]  e;
    f = 14'($urandom);
    case ($urandom_range(0, 3))
      0: f = f >> $urandom_range(1, 13);
      1: f[13] = 1'b0;
      default: ;
    endcase
    e = 5'($urandom_range(0, 30));
    return {1'($urandom), 1'($urandom), e, f};
  endfunction

  // Called at a falling edge: drive, sample 1ns later, advance to the next falling edge.
  task automatic step(input logic vin, input logic [20:0] beat, input logic ordy,
                      output logic acc_in, output logic ov, output logic [15:0] res,
                      output logic ovf, output logic irdy);
    in_valid  = vin;
    {sign_in, sticky_in, exp_in, frac_in} = beat;
    out_ready = ordy;
    #1;
    irdy   = in_ready;
    acc_in = vin & in_ready;
    ov     = out_valid;
    res    = result;
    ovf    = overflow;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    if (out_valid !== 1'b0) errors++;
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h want=0000", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [20:0] beats [11];
    logic [16:0] want [11];
    logic a, ov, ovf, ir;
    logic [15:0] res;
    beats = '{{2'b00, 5'd15, 14'h2000}, {2'b00, 5'd15, 14'h0800}, {2'b00, 5'd15, 14'h0000},
              {2'b10, 5'd15, 14'h0000}, {2'b00, 5'd15, 14'h1002}, {2'b00, 5'd15, 14'h1006},
              {2'b01, 5'd15, 14'h1002}, {2'b00, 5'd15, 14'h1FFE}, {2'b00, 5'd30, 14'h2000},
              {2'b00, 5'd1,  14'h0400}, {2'b00, 5'd0,  14'h1000}};
    want  = '{17'h04000, 17'h03800, 17'h00000, 17'h08000, 17'h03C00, 17'h03C02,
              17'h03C01, 17'h04000, 17'h17C00, 17'h00100, 17'h00400};
    for (int i = 0; i < 11; i++) begin
      step(1'b1, beats[i], 1'b1, a, ov, res, ovf, ir);
      checks++;
      if (a !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got=%b want=1", i, a); end
      step(1'b0, 21'd0, 1'b1, a, ov, res, ovf, ir);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL dir%0d_latency1 out_valid got=%b want=0", i, ov); end
      step(1'b0, 21'd0, 1'b1, a, ov, res, ovf, ir);
      checks++;
      if (ov !== 1'b1 || {ovf, res} !== want[i]) begin
        errors++;
        $display("FAIL dir%0d_result valid=%b got=%b/%h want=%b/%h", i, ov, ovf, res,
                 want[i][16], want[i][15:0]);
      end
    end
  endtask

  task automatic test_random();
    logic a, ov, ovf, ir, vin, ordy, prev_stall, prev_ovf;
    logic [15:0] res, prev_res;
    logic [20:0] b;
    logic [16:0] w;
    int n;
    prev_stall = 1'b0;
    prev_res   = '0;
    prev_ovf   = 1'b0;
    for (int c = 0; c < 450; c++) begin
      vin  = (c < 400) ? ($urandom_range(0, 9) < 7) : 1'b0;
      ordy = (c < 400) ? ($urandom_range(0, 9) < 6) : 1'b1;
      b    = rand_beat();
      step(vin, b, ordy, a, ov, res, ovf, ir);
      if (prev_stall) begin
        checks++;
        if (ov !== 1'b1 || res !== prev_res || ovf !== prev_ovf) begin
          errors++;
          $display("FAIL rnd_hold c=%0d valid=%b got=%b/%h want=%b/%h", c, ov, ovf, res, prev_ovf, prev_res);
        end
      end
      if (ov && ordy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious c=%0d got=%h want=none", c, res);
        end else begin
          w = exp_q.pop_front();
          if ({ovf, res} !== w) begin
            errors++;
            $display("FAIL rnd_result c=%0d got=%b/%h want=%b/%h", c, ovf, res, w[16], w[15:0]);
          end
        end
      end
      if (a) exp_q.push_back(model_beat(b));
      prev_stall = ov & ~ordy;
      prev_res   = res;
      prev_ovf   = ovf;
    end
    n = exp_q.size();
    checks++;
    if (n != 0) begin errors++; $display("FAIL rnd_drain left=%0d want=0", n); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic a, ov, ovf, ir;
    logic [15:0] res;
    logic [20:0] b;
    logic [16:0] w;
    for (int c = 0; c < 18; c++) begin
      b = rand_beat();
      step(c < 16, b, 1'b1, a, ov, res, ovf, ir);
      if (c < 16) begin
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL b2b_accept c=%0d got=%b want=1", c, a); end
        exp_q.push_back(model_beat(b));
      end
      if (c >= 2) begin
        checks++;
        w = exp_q.pop_front();
        if (ov !== 1'b1 || {ovf, res} !== w) begin
          errors++;
          $display("FAIL b2b_result c=%0d valid=%b got=%b/%h want=%b/%h", c, ov, ovf, res, w[16], w[15:0]);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic a, ov, ovf, ir;
    logic [15:0] res, held;
    logic [20:0] bp [4];
    logic [16:0] w;
    int idx, rcv, c;
    for (int i = 0; i < 4; i++) bp[i] = {2'b00, 5'(10 + i), 14'h1000 | 14'(i * 8)};
    idx  = 0;
    rcv  = 0;
    held = '0;
    for (int k = 0; k < 4; k++) begin
      step(idx < 4, (idx < 4) ? bp[idx] : 21'd0, 1'b0, a, ov, res, ovf, ir);
      if (a) begin exp_q.push_back(model_beat(bp[idx])); idx++; end
      if (k >= 2) begin
        checks++;
        if (ir !== 1'b0 || ov !== 1'b1) begin
          errors++;
          $display("FAIL bp_stall k=%0d in_ready=%b out_valid=%b want 0/1", k, ir, ov);
        end
      end
      if (k == 2) held = res;
      if (k == 3) begin
        checks++;
        if (res !== held) begin errors++; $display("FAIL bp_hold got=%h want=%h", res, held); end
      end
    end
    checks++;
    if (idx != 2) begin errors++; $display("FAIL bp_accepted got=%0d want=2", idx); end
    c = 0;
    while ((rcv < 4 || idx < 4) && c < 20) begin
      step(idx < 4, (idx < 4) ? bp[idx] : 21'd0, 1'b1, a, ov, res, ovf, ir);
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra got=%h want=none", res);
        end else begin
          w = exp_q.pop_front();
          if ({ovf, res} !== w) begin
            errors++;
            $display("FAIL bp_result n=%0d got=%b/%h want=%b/%h", rcv, ovf, res, w[16], w[15:0]);
          end
        end
        rcv++;
      end
      if (a) begin exp_q.push_back(model_beat(bp[idx])); idx++; end
      c++;
    end
    checks++;
    if (rcv != 4) begin errors++; $display("FAIL bp_count got=%0d want=4", rcv); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 21'd0, 1'b1, a, ov, res, ovf, ir);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL bp_dup k=%0d out_valid got=%b want=0", k, ov); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic a, ov, ovf, ir;
    logic [15:0] res;
    step(1'b1, {2'b00, 5'd15, 14'h1000}, 1'b0, a, ov, res, ovf, ir);
    step(1'b1, {2'b00, 5'd16, 14'h1000}, 1'b0, a, ov, res, ovf, ir);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 16'h3C00) begin
      errors++;
      $display("FAIL rstmid_pre valid=%b got=%h want=1/3c00", out_valid, result);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear valid=%b result=%h ovf=%b want 0/0000/0", out_valid, result, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 21'd0, 1'b1, a, ov, res, ovf, ir);
      checks++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_stale k=%0d out_valid=%b in_ready=%b want 0/1", k, ov, ir);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    sticky_in = 1'b0;
    frac_in   = '0;
    exp_in    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
